// File: rtl/bus_pkg.sv
// Shared types and defaults for the snooping-bus arbiter and its round-robin picker.
package bus_pkg;

  localparam int unsigned N_MASTERS_DEF      = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    BUSRD     = 3'b000,
    BUSRDX    = 3'b001,
    BUSUPGR   = 3'b010,
    WRITEBACK = 3'b011
  } bus_op_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/snoop_bus_arbiter_rr_picker.sv
// Combinational winner selection: a pending lock wins, otherwise the first
// requester found scanning upward from ptr with wraparound.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          lock_valid,
  input  logic [IW-1:0] lock_id,
  output logic [IW-1:0] winner,
  output logic          any,
  output logic          used_lock
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    any       = |req;
    used_lock = lock_valid && req[lock_id];
    winner    = ptr;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    if (used_lock) begin
      winner = lock_id;
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snooping-bus arbiter with writeback-then-refill lock.
// Optional grant watchdog enabled by defining SNOOP_ARB_TIMEOUT_EN.
module snoop_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned N_MASTERS      = N_MASTERS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MASTERS-1:0]         BusReq,
  input  logic                         BusValid,
  input  logic [2:0]                   BusOp,
  output logic [N_MASTERS-1:0]         BusGrant,
  output logic                         BusBusy,
  output logic [$clog2(N_MASTERS)-1:0] Owner,
  output logic                         ArbTimeout
);

  localparam int unsigned IW = $clog2(N_MASTERS);

  if (N_MASTERS < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("snoop_bus_arbiter: needs N_MASTERS >= 2 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t           state, state_nx;
  logic [IW-1:0]        rr_ptr, owner_id, lock_id, winner, owner_nx, next_id;
  logic                 lock_valid, used_lock_q, any_req, used_lock;
  logic                 pick, release_now, ack, writeback, timeout_hit;
  logic [N_MASTERS-1:0] grant_nx;

  // Only a clean 1 acknowledges; X/Z on BusValid is treated as no response.
  assign ack       = (BusValid === 1'b1);
  assign writeback = ack && (bus_op_t'(BusOp) == WRITEBACK);
  assign next_id   = (owner_id == IW'(N_MASTERS - 1)) ? '0 : owner_id + 1'b1;

  rr_picker #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_picker (
    .req        (BusReq),
    .ptr        (rr_ptr),
    .lock_valid (lock_valid),
    .lock_id    (lock_id),
    .winner     (winner),
    .any        (any_req),
    .used_lock  (used_lock)
  );

  always_comb begin
    state_nx    = state;
    pick        = 1'b0;
    release_now = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = GRANTED;
          pick     = 1'b1;
        end
      end
      GRANTED: begin
        if (ack || !BusReq[owner_id] || timeout_hit) begin
          state_nx    = RELEASE;
          release_now = 1'b1;
        end
      end
      RELEASE: begin
        if (any_req) begin
          state_nx = GRANTED;
          pick     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    owner_nx = pick ? winner : owner_id;
    grant_nx = '0;
    if (state_nx == GRANTED) begin
      grant_nx[owner_nx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      BusGrant    <= '0;
      BusBusy     <= 1'b0;
      Owner       <= '0;
      rr_ptr      <= '0;
      owner_id    <= '0;
      lock_valid  <= 1'b0;
      lock_id     <= '0;
      used_lock_q <= 1'b0;
    end else begin
      state    <= state_nx;
      BusGrant <= grant_nx;
      BusBusy  <= (state_nx == GRANTED);
      Owner    <= (state_nx == GRANTED) ? owner_nx : '0;
      if (pick) begin
        owner_id    <= winner;
        used_lock_q <= used_lock;
        lock_valid  <= 1'b0;
      end
      if (release_now) begin
        // A lock-granted refill leaves the rotation where the writeback left it.
        if (!used_lock_q || timeout_hit) begin
          rr_ptr <= next_id;
        end
        if (writeback) begin
          lock_valid <= 1'b1;
          lock_id    <= owner_id;
        end
      end
    end
  end

`ifdef SNOOP_ARB_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wdog;

  assign timeout_hit = (state == GRANTED) && !ack && (wdog == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wdog       <= '0;
      ArbTimeout <= 1'b0;
    end else begin
      ArbTimeout <= timeout_hit;
      wdog       <= (state == GRANTED && state_nx == GRANTED) ? wdog + 1'b1 : '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign ArbTimeout  = 1'b0;
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_snoop_bus_arbiter;

  localparam int unsigned TO = 64;
  localparam int NV = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] BusReq;
  logic       BusValid;
  logic [2:0] BusOp;
  logic [3:0] BusGrant;
  logic       BusBusy;
  logic [1:0] Owner;
  logic       ArbTimeout;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [3:0]  prev_g = 4'b0000;

  typedef struct {
    logic [3:0] req;
    logic       valid;
    logic [2:0] op;
    logic [3:0] g;
    logic       b;
    logic [1:0] o;
  } vec_t;

  vec_t tv [NV];

  always #5 clk = ~clk;

  snoop_bus_arbiter #(
    .N_MASTERS      (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .BusReq     (BusReq),
    .BusValid   (BusValid),
    .BusOp      (BusOp),
    .BusGrant   (BusGrant),
    .BusBusy    (BusBusy),
    .Owner      (Owner),
    .ArbTimeout (ArbTimeout)
  );

  task automatic check(input string name, input logic [3:0] g, input logic b,
                       input logic [1:0] o, input logic t);
    n_vec++;
    if (BusGrant !== g || BusBusy !== b || Owner !== o || ArbTimeout !== t) begin
      n_err++;
      $display("FAIL %s: got grant=%b busy=%b owner=%0d tmo=%b, want grant=%b busy=%b owner=%0d tmo=%b",
               name, BusGrant, BusBusy, Owner, ArbTimeout, g, b, o, t);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    BusReq   = 4'b0000;
    BusValid = 1'b0;
    BusOp    = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    reset = 1'b1;
  endtask

  // Grants must stay one-hot and two owners must be separated by a zero cycle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if ($countones(BusGrant) > 1) begin
        n_err++;
        $display("FAIL onehot: got grant=%b, want at most one bit set", BusGrant);
      end
      if (prev_g != 4'b0000 && BusGrant != 4'b0000 && BusGrant != prev_g) begin
        n_err++;
        $display("FAIL gap: got grant %b -> %b, want a zero cycle between owners", prev_g, BusGrant);
      end
    end
    prev_g <= BusGrant;
  end

  initial begin
    logic [3:0] eg;
    logic [1:0] eid;

    // req, valid, op, expected grant, busy, owner (outputs seen in the same cycle)
    tv[0]  = '{4'b0001, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd0};
    tv[1]  = '{4'b0001, 1'b0, 3'b000, 4'b0001, 1'b1, 2'd0};
    tv[2]  = '{4'b0001, 1'b0, 3'b000, 4'b0001, 1'b1, 2'd0};
    tv[3]  = '{4'b0001, 1'b0, 3'b000, 4'b0001, 1'b1, 2'd0};
    tv[4]  = '{4'b0001, 1'b1, 3'b000, 4'b0001, 1'b1, 2'd0};
    tv[5]  = '{4'b0000, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd0};
    tv[6]  = '{4'b0011, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd0};
    tv[7]  = '{4'b0011, 1'b0, 3'b000, 4'b0010, 1'b1, 2'd1};
    tv[8]  = '{4'b0001, 1'b0, 3'b000, 4'b0010, 1'b1, 2'd1};
    tv[9]  = '{4'b0001, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd0};
    tv[10] = '{4'b0001, 1'b0, 3'b000, 4'b0001, 1'b1, 2'd0};
    tv[11] = '{4'b0001, 1'b1, 3'b001, 4'b0001, 1'b1, 2'd0};
    tv[12] = '{4'b0000, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd0};
    tv[13] = '{4'b1100, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd0};
    tv[14] = '{4'b1100, 1'b0, 3'b000, 4'b0100, 1'b1, 2'd2};
    tv[15] = '{4'b1000, 1'b1, 3'b011, 4'b0100, 1'b1, 2'd2};
    tv[16] = '{4'b1100, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd0};
    tv[17] = '{4'b1100, 1'b0, 3'b011, 4'b0100, 1'b1, 2'd2};
    tv[18] = '{4'b1100, 1'b1, 3'b000, 4'b0100, 1'b1, 2'd2};
    tv[19] = '{4'b1100, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd0};
    tv[20] = '{4'b1101, 1'b0, 3'b000, 4'b1000, 1'b1, 2'd3};
    tv[21] = '{4'b1111, 1'b0, 3'b000, 4'b1000, 1'b1, 2'd3};
    tv[22] = '{4'b1000, 1'b1, 3'b000, 4'b1000, 1'b1, 2'd3};
    tv[23] = '{4'b0000, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd0};
    tv[24] = '{4'b0000, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd0};

    do_reset();
    for (int i = 0; i < NV; i++) begin
      BusReq   = tv[i].req;
      BusValid = tv[i].valid;
      BusOp    = tv[i].op;
      check($sformatf("vec%0d", i), tv[i].g, tv[i].b, tv[i].o, 1'b0);
      @(negedge clk);
    end
    BusValid = 1'b0;
    BusReq   = 4'b0000;

    // All masters requesting, each acked three cycles after its grant.
    do_reset();
    BusReq = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      eid = 2'(k % 4);
      eg  = 4'b0001 << eid;
      check($sformatf("rr_grant%0d", k), eg, 1'b1, eid, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      BusValid = 1'b1;
      check($sformatf("rr_hold%0d", k), eg, 1'b1, eid, 1'b0);
      @(negedge clk);
      BusValid = 1'b0;
      check($sformatf("rr_gap%0d", k), 4'b0000, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
    end
    BusReq = 4'b0000;

    // Reset while granted drops the grant at that edge.
    do_reset();
    BusReq = 4'b0001;
    @(negedge clk);
    check("pre_rst_grant", 4'b0001, 1'b1, 2'd0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid", 4'b0000, 1'b0, 2'd0, 1'b0);
    reset  = 1'b1;
    BusReq = 4'b0010;
    @(negedge clk);
    check("after_rst", 4'b0010, 1'b1, 2'd1, 1'b0);

    // Grant never acknowledged.
    do_reset();
    BusReq = 4'b0001;
    @(negedge clk);
    for (int i = 0; i < int'(TO); i++) begin
      check($sformatf("wdog_hold%0d", i), 4'b0001, 1'b1, 2'd0, 1'b0);
      @(negedge clk);
    end
`ifdef SNOOP_ARB_TIMEOUT_EN
    check("wdog_expire", 4'b0000, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    check("wdog_regrant", 4'b0001, 1'b1, 2'd0, 1'b0);
`else
    check("no_wdog_a", 4'b0001, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    check("no_wdog_b", 4'b0001, 1'b1, 2'd0, 1'b0);
`endif
    BusReq = 4'b0000;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
